div_8by4: RTL and testbench
===========================

DIV_8BY4 -- requirements
Module: div_8by4

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  request strobe; a request is accepted only on an edge where i_valid=1 and i_ready=1.
REQ-005 dividend  input  8  unsigned dividend; sampled only on the accept edge.
REQ-006 divisor  input  4  unsigned divisor; sampled only on the accept edge.
REQ-007 i_ready  output  1  high only in IDLE; request may be accepted.
REQ-008 quotient  output  8  unsigned quotient; registered.
REQ-009 remainder  output  4  unsigned remainder; registered.
REQ-010 div_by_zero  output  1  registered flag; high when the last result came from a zero divisor.
REQ-011 o_valid  output  1  one-cycle result strobe.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-013 On an IDLE accept edge with divisor!=0, the block SHALL latch both operands, clear the 5-bit partial remainder and the quotient shift register, clear the iteration counter, and move to CALC.
REQ-014 On an IDLE accept edge with divisor==0, the block SHALL load quotient=8'hFF, remainder=dividend[3:0] and div_by_zero=1, and move directly to DONE.
REQ-015 Each CALC edge SHALL perform one restoring step, MSB of the dividend first.
- Step: p = {partial[3:0], next dividend bit}.
- If p >= divisor: partial = p - divisor and the quotient bit is 1.
- Otherwise: partial = p and the quotient bit is 0.
REQ-016 CALC SHALL last exactly 8 edges. On the 8th edge the block SHALL load quotient, remainder=partial[3:0] and div_by_zero=0, and move to DONE.
REQ-017 o_valid SHALL be 1 exactly during the DONE cycle. DONE SHALL return to IDLE on the next edge unconditionally.
REQ-018 Latency SHALL be as follows, with no throughput overlap:
- Normal request: o_valid is high in the cycle after the 9th edge following acceptance (accept edge + 8 CALC edges).
- Zero-divisor request: o_valid is high in the cycle after the accept edge.
REQ-019 i_valid asserted while in CALC or DONE SHALL be ignored. Operands SHALL NOT be re-sampled, and no request SHALL be queued.
REQ-020 quotient, remainder and div_by_zero SHALL hold their last value until the next result load, including through IDLE.
REQ-021 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor!=0. All arithmetic is unsigned.
REQ-022 Operand changes after the accept edge SHALL NOT affect the result in progress.

Reset
REQ-023 While rst_n=0, the block SHALL immediately force:
- state=IDLE, i_ready=1;
- quotient=0, remainder=0, div_by_zero=0, o_valid=0;
- counter and partial remainder to 0.
REQ-024 Reset asserted during CALC or DONE SHALL abort the operation. No o_valid SHALL follow, and the first edge after release SHALL be able to accept a new request.
REQ-025 On the first edge after rst_n deasserts, the block SHALL be fully functional. No extra idle cycle is permitted.

Verification
REQ-026 Basic division: dividend=200, divisor=7 -> o_valid pulse 9 edges after accept; quotient=28, remainder=4, div_by_zero=0.
REQ-027 Edge values:
- 255/1 -> quotient=255, remainder=0.
- 15/15 -> quotient=1, remainder=0.
- 3/9 -> quotient=0, remainder=3.
REQ-028 Divide by zero: dividend=100, divisor=0 -> o_valid in the cycle after accept; quotient=8'hFF, remainder=4, div_by_zero=1. A following 10/3 request -> quotient=3, remainder=1, div_by_zero=0.
REQ-029 Busy rejection: hold i_valid=1 and change operands every cycle during CALC.
- The result matches the originally accepted operands.
- i_ready=0 throughout CALC and DONE.
- Exactly one o_valid pulse is produced per accept.
REQ-030 Reset mid-operation: assert rst_n=0 on CALC cycle 4.
- All outputs go to 0 asynchronously and no o_valid follows.
- After release, 50/5 yields quotient=10, remainder=0.
REQ-031 Exhaustive check: all 4096 operand pairs are issued back-to-back at maximum rate, and each result matches the REQ-021 reference model, plus REQ-014 for divisor=0.

Source files
------------

// File: rtl/div_8by4.sv
// 8-bit by 4-bit unsigned restoring divider. Each accepted request takes eight CALC cycles.
// A zero divisor skips CALC and reports a saturated quotient.
module div_8by4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_valid,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic       i_ready,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       div_by_zero,
   output logic       o_valid
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] dvd_q, dvd_d;
   logic [3:0] dvs_q, dvs_d;
   logic [4:0] part_q, part_d;
   logic [7:0] qsr_q, qsr_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] quot_q, quot_d;
   logic [3:0] rem_q, rem_d;
   logic       dbz_q, dbz_d;

   logic       accept;
   logic [4:0] trial;
   logic [4:0] diff;
   logic       ge;

   assign accept = (state_q == StIdle) && i_valid;

   // The dividend register shifts left, so bit 7 always holds the next bit to bring down.
   assign trial = {part_q[3:0], dvd_q[7]};
   assign ge    = trial >= {1'b0, dvs_q};
   assign diff  = trial - {1'b0, dvs_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = (divisor == 4'd0) ? StDone : StCalc;
            end
         end
         StCalc: begin
            if (cnt_q == 3'd7) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dvd_d  = dvd_q;
      dvs_d  = dvs_q;
      part_d = part_q;
      qsr_d  = qsr_q;
      cnt_d  = cnt_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      if (accept) begin
         dvd_d  = dividend;
         dvs_d  = divisor;
         part_d = 5'd0;
         qsr_d  = 8'd0;
         cnt_d  = 3'd0;
         if (divisor == 4'd0) begin
            quot_d = 8'hFF;
            rem_d  = dividend[3:0];
            dbz_d  = 1'b1;
         end
      end else if (state_q == StCalc) begin
         dvd_d  = {dvd_q[6:0], 1'b0};
         part_d = ge ? diff : trial;
         qsr_d  = {qsr_q[6:0], ge};
         cnt_d  = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            quot_d = {qsr_q[6:0], ge};
            rem_d  = ge ? diff[3:0] : trial[3:0];
            dbz_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q  <= 8'd0;
         dvs_q  <= 4'd0;
         part_q <= 5'd0;
         qsr_q  <= 8'd0;
         cnt_q  <= 3'd0;
         quot_q <= 8'd0;
         rem_q  <= 4'd0;
         dbz_q  <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         part_q <= part_d;
         qsr_q  <= qsr_d;
         cnt_q  <= cnt_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dbz_q  <= dbz_d;
      end
   end

   always_comb begin
      i_ready     = (state_q == StIdle);
      o_valid     = (state_q == StDone);
      quotient    = quot_q;
      remainder   = rem_q;
      div_by_zero = dbz_q;
   end

endmodule

// File: tb/tb_div_8by4.sv
// Scoreboard bench for div_8by4: expected results are queued at issue and checked on o_valid.
// Covers reset, edge operands, divide by zero, busy rejection, mid-op reset and all 4096 pairs.
module tb_div_8by4;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] dividend = 8'd0;
   logic [3:0] divisor = 4'd0;
   logic       i_ready;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;
   logic       o_valid;

   int   compared = 0;
   int   mismatched = 0;
   int   results = 0;
   exp_t sb[$];
   exp_t mon_e;

   div_8by4 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (i_valid),
      .dividend    (dividend),
      .divisor     (divisor),
      .i_ready     (i_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .o_valid     (o_valid)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
      exp_t e;
      if (b == 4'd0) begin
         e.q = 8'hFF;
         e.r = a[3:0];
         e.z = 1'b1;
      end else begin
         e.q = a / {4'd0, b};
         e.r = 4'(a % {4'd0, b});
         e.z = 1'b0;
      end
      return e;
   endfunction

   // Every o_valid pulse is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (o_valid === 1'b1) begin
         results++;
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_result: got q=%0d r=%0d dbz=%0b, required no o_valid",
                     quotient, remainder, div_by_zero);
         end else begin
            mon_e = sb.pop_front();
            if ({quotient, remainder, div_by_zero} !== mon_e) begin
               mismatched++;
               $display("FAIL result: got q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                        quotient, remainder, div_by_zero, mon_e.q, mon_e.r, mon_e.z);
            end
         end
      end
   end

   // Issues one request; optionally keeps i_valid high with changing operands while busy.
   task automatic do_req(input logic [7:0] a, input logic [3:0] b, input bit noise,
                         input string name);
      int n;
      int lat;
      int pulses;
      int exp_lat;
      exp_lat = (b == 4'd0) ? 1 : 9;
      n = 0;
      while (i_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (i_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL %s_idle_wait: i_ready=%b, required 1 within 40 cycles", name, i_ready);
         return;
      end
      dividend = a;
      divisor  = b;
      i_valid  = 1'b1;
      sb.push_back(model(a, b));
      @(negedge clk);
      lat    = 0;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         if (o_valid === 1'b1) begin
            pulses++;
            if (lat == 0) lat = k;
         end
         if (lat == 0 || k == lat) begin
            compared++;
            if (i_ready !== 1'b0) begin
               mismatched++;
               $display("FAIL %s_busy_ready: cycle %0d i_ready=%b, required 0", name, k, i_ready);
            end
         end
         if (noise && lat == 0) begin
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            i_valid  = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         if (lat != 0 && k >= lat + 2) break;
         @(negedge clk);
      end
      i_valid = 1'b0;
      compared++;
      if (lat != exp_lat) begin
         mismatched++;
         $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
      end
      compared++;
      if (pulses != 1) begin
         mismatched++;
         $display("FAIL %s_pulses: got %0d o_valid pulses, required 1", name, pulses);
      end
   endtask

   task automatic test_reset();
      #3;
      compared++;
      if ({quotient, remainder, div_by_zero, o_valid, i_ready} !== 15'b1) begin
         mismatched++;
         $display("FAIL reset_state: got q=%0d r=%0d dbz=%b ov=%b rdy=%b, required 0 0 0 0 1",
                  quotient, remainder, div_by_zero, o_valid, i_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      do_req(8'd200, 4'd7, 1'b0, "basic_200_7");
   endtask

   task automatic test_edges();
      do_req(8'd255, 4'd1, 1'b0, "edge_255_1");
      do_req(8'd15, 4'd15, 1'b0, "edge_15_15");
      do_req(8'd3, 4'd9, 1'b0, "edge_3_9");
   endtask

   task automatic test_div_zero();
      do_req(8'd100, 4'd0, 1'b0, "dbz_100_0");
      do_req(8'd10, 4'd3, 1'b0, "after_dbz_10_3");
   endtask

   task automatic test_hold();
      do_req(8'd123, 4'd10, 1'b0, "hold_123_10");
      repeat (4) @(negedge clk);
      compared++;
      if ({quotient, remainder, div_by_zero} !== {8'd12, 4'd3, 1'b0}) begin
         mismatched++;
         $display("FAIL hold: got q=%0d r=%0d dbz=%b, required q=12 r=3 dbz=0",
                  quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_busy();
      do_req(8'd77, 4'd6, 1'b1, "busy_77_6");
      do_req(8'd250, 4'd13, 1'b1, "busy_250_13");
   endtask

   task automatic test_reset_mid();
      int pulses;
      dividend = 8'd200;
      divisor  = 4'd7;
      i_valid  = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if ({quotient, remainder, div_by_zero, o_valid, i_ready} !== 15'b1) begin
         mismatched++;
         $display("FAIL reset_mid_async: got q=%0d r=%0d dbz=%b ov=%b rdy=%b, required 0 0 0 0 1",
                  quotient, remainder, div_by_zero, o_valid, i_ready);
      end
      sb.delete();
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (o_valid === 1'b1) pulses++;
      end
      rst_n = 1'b1;
      compared++;
      if (pulses != 0) begin
         mismatched++;
         $display("FAIL reset_mid_no_valid: got %0d pulses, required 0", pulses);
      end
      do_req(8'd50, 4'd5, 1'b0, "post_reset_50_5");
   endtask

   task automatic test_exhaustive();
      int         issued;
      int         cyc;
      int         base;
      logic [11:0] v;
      issued = 0;
      cyc    = 0;
      base   = results;
      @(negedge clk);
      while ((results - base) < 4096 && cyc < 60000) begin
         if (i_ready === 1'b1) begin
            if (issued < 4096) begin
               v        = 12'(issued);
               dividend = v[11:4];
               divisor  = v[3:0];
               i_valid  = 1'b1;
               sb.push_back(model(v[11:4], v[3:0]));
               issued++;
            end else begin
               i_valid = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      i_valid = 1'b0;
      compared++;
      if ((results - base) != 4096) begin
         mismatched++;
         $display("FAIL exhaustive_count: got %0d results, required 4096", results - base);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_div_zero();
      test_hold();
      test_busy();
      test_reset_mid();
      test_exhaustive();
      repeat (4) @(negedge clk);
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
